mips_muldiv_unit: RTL
=====================

Name: mips_muldiv_unit

Overview:
- Parametrised iterative multiply/divide unit with architectural HI/LO registers for the pipelined MIPS core.
- Sits beside the EX-stage ALU and executes MULT, MULTU, DIV, DIVU, MTHI and MTLO.
- Raises busy so the hazard logic can stall any MFHI/MFLO or new mul/div issued while an operation is in flight.
- Generalises the core's single-cycle ALU datapath to a configurable width with a multi-cycle handshake and flush support.

Parameters:
- DATA_WIDTH, 32, operand and HI/LO width W; must be at least 4.
- DIV0_LO, all ones (W bits), value written to LO on divide by zero.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- start  in  1  request; sampled on the rising edge of clk
- op  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110/111 no-op
- src_a  in  W  rs operand (multiplicand/dividend; MTHI/MTLO data)
- src_b  in  W  rt operand (multiplier/divisor)
- cancel  in  1  pipeline flush; aborts an in-flight operation
- busy  out  1  operation in flight; hazard unit stalls on it
- done  out  1  one-cycle pulse when HI/LO update from a mul/div
- hi  out  W  HI register
- lo  out  W  LO register

Behaviour:
- Interface: single clock clk. rst is synchronous and active-low.
- Reset: rst=0 at a rising edge gives state IDLE, hi=0, lo=0, busy=0, done=0.
  - This holds regardless of the current state; a mid-operation reset discards the operation.
- FSM states: IDLE, RUN, FIX.
- IDLE:
  - Accepts start=1 with cancel=0.
  - MULT/MULTU/DIV/DIVU: latch operands and signed flag, counter=0, go to RUN, busy=1 from the next cycle.
  - MTHI/MTLO: write hi/lo directly at that edge, stay in IDLE, busy=0, done=0.
  - Ops 110/111 are ignored.
- RUN:
  - One radix-2 step per cycle on operand magnitudes: shift-add for multiply, restoring shift-subtract for divide.
  - After W steps (counter == W-1) go to FIX.
- FIX (one cycle):
  - Apply sign correction and select the result.
  - At the FIX edge, write hi/lo, go to IDLE, busy=0, done=1 for exactly that following cycle.
- Latency: start accepted at edge E0; busy high after E0 through E0+W+1; result and done visible after edge E0+W+1. For W=32 that is 33 edges.
- start while busy is ignored and not queued. The hazard unit must hold the instruction.
- hi/lo keep their previous values throughout RUN/FIX; only the completing edge changes them.
- Multiply result is the full 2W-bit product: {hi,lo}.
  - Signed: two's complement of operands and result.
  - Unsigned: zero-extended.
- Divide: lo = quotient, hi = remainder.
  - Signed quotient truncates toward zero; remainder takes the sign of the dividend.
- Divide by zero (src_b == 0, signed or unsigned): completes with normal latency, hi = dividend unmodified, lo = DIV0_LO.
- Signed overflow (most-negative / -1): lo = most-negative, hi = 0, no trap.
- cancel:
  - In RUN or FIX: return to IDLE at that edge, busy=0 next cycle, no done, hi/lo unchanged.
  - In IDLE: suppresses a same-cycle start, including MTHI/MTLO.
- cancel on the FIX edge beats completion.
- done never asserts outside the cycle after a FIX edge; busy and done are never both 1.

Test Plan:
- Reset: hold rst=0 for 2 edges then release -> hi=0, lo=0, busy=0, done=0. Assert rst=0 mid-RUN -> same values next cycle, no done.
- MULT: -3 x 5 (0xFFFFFFFD, 0x00000005) -> busy for 33 cycles, done pulse, hi=0xFFFFFFFF, lo=0xFFFFFFF1. MULTU of the same operands -> hi=0x00000004, lo=0xFFFFFFF1.
- DIV: -7 / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 100 / 7 -> lo=0x0000000E, hi=0x00000002.
- Boundaries:
  - DIVU 0x00001234 / 0 -> hi=0x00001234, lo=0xFFFFFFFF after 33 cycles.
  - DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0x00000000.
- Handshake:
  - MTHI 0xA5A5A5A5 -> hi updates next cycle, busy stays 0.
  - start a DIV, then re-assert start with MULT at cycle 5 -> the MULT is ignored and the DIV result is correct.
- Flush:
  - Issue MULT, then cancel at cycle 10 -> busy=0 next cycle, no done, hi/lo keep the prior values.
  - start+cancel in the same cycle in IDLE -> no operation.
  - cancel on the FIX cycle -> no update.
- Parameter: DATA_WIDTH=8, MULT 0x80 x 0x80 -> hi=0x40, lo=0x00, with done after 9 edges.

Source files
------------

// File: rtl/mips_muldiv_if.sv
// Handshake and result bundle between the EX stage and the multiply/divide unit.
interface mips_muldiv_if #(
    parameter int DATA_WIDTH = 32
) ();
    logic                  start;
    logic [2:0]            op;
    logic [DATA_WIDTH-1:0] src_a;
    logic [DATA_WIDTH-1:0] src_b;
    logic                  cancel;
    logic                  busy;
    logic                  done;
    logic [DATA_WIDTH-1:0] hi;
    logic [DATA_WIDTH-1:0] lo;

    modport master (
        output start, op, src_a, src_b, cancel,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, src_a, src_b, cancel,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/mips_muldiv_unit.sv
// Iterative radix-2 multiply/divide unit owning the architectural HI/LO registers.
// Works on operand magnitudes for W cycles, then fixes signs in a single FIX cycle.
module mips_muldiv_unit #(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] DIV0_LO    = {DATA_WIDTH{1'b1}}
) (
    input  logic           clk,
    input  logic           rst,
    mips_muldiv_if.slave   bus
);
    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(DATA_WIDTH);

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t            state_r;
    state_t            state_s;
    logic [CW-1:0]     cnt_r;
    logic [2*W-1:0]    p_r;
    logic [W-1:0]      mag_a_r;
    logic [W-1:0]      mag_b_r;
    logic [W-1:0]      a_r;
    logic              is_div_r;
    logic              b_zero_r;
    logic              neg_q_r;
    logic              neg_r_r;
    logic [W-1:0]      hi_r;
    logic [W-1:0]      lo_r;
    logic              busy_r;
    logic              done_r;

    logic              accept_s;
    logic              last_step_s;
    logic [W:0]        mul_sum_s;
    logic [2*W-1:0]    mul_next_s;
    logic [W:0]        div_shift_s;
    logic [W:0]        div_diff_s;
    logic [2*W-1:0]    div_next_s;
    logic [2*W-1:0]    prod_s;
    logic [W-1:0]      res_hi_s;
    logic [W-1:0]      res_lo_s;

    function automatic logic [W-1:0] magnitude(input logic [W-1:0] v, input logic sgn);
        return (sgn && v[W-1]) ? -v : v;
    endfunction

    assign accept_s    = bus.start && !bus.cancel && (state_r == IDLE);
    assign last_step_s = (cnt_r == CW'(W - 1));

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; a flush always wins over progress or completion
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s && !bus.op[2]) begin
                    state_s = RUN;
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                if (bus.cancel) begin
                    state_s = IDLE;
                end else if (last_step_s) begin
                    state_s = FIX;
                end else begin
                    state_s = RUN;
                end
            end
            FIX:     state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // One radix-2 step: shift-add multiply, restoring shift-subtract divide
    always_comb begin
        mul_sum_s   = {1'b0, p_r[2*W-1:W]} + (p_r[0] ? {1'b0, mag_a_r} : {(W+1){1'b0}});
        mul_next_s  = {mul_sum_s, p_r[W-1:1]};
        div_shift_s = p_r[2*W-1:W-1];
        div_diff_s  = div_shift_s - {1'b0, mag_b_r};
        if (!div_diff_s[W]) begin
            div_next_s = {div_diff_s[W-1:0], p_r[W-2:0], 1'b1};
        end else begin
            div_next_s = {div_shift_s[W-1:0], p_r[W-2:0], 1'b0};
        end
    end

    // Sign correction and result selection for the FIX cycle
    always_comb begin
        prod_s   = neg_q_r ? -p_r : p_r;
        res_hi_s = prod_s[2*W-1:W];
        res_lo_s = prod_s[W-1:0];
        if (is_div_r) begin
            if (b_zero_r) begin
                res_hi_s = a_r;
                res_lo_s = DIV0_LO;
            end else begin
                res_lo_s = neg_q_r ? -p_r[W-1:0]   : p_r[W-1:0];
                res_hi_s = neg_r_r ? -p_r[2*W-1:W] : p_r[2*W-1:W];
            end
        end else begin
            res_hi_s = prod_s[2*W-1:W];
            res_lo_s = prod_s[W-1:0];
        end
    end

    // Datapath, HI/LO and registered handshake outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_r    <= {CW{1'b0}};
            p_r      <= {(2*W){1'b0}};
            mag_a_r  <= {W{1'b0}};
            mag_b_r  <= {W{1'b0}};
            a_r      <= {W{1'b0}};
            is_div_r <= 1'b0;
            b_zero_r <= 1'b0;
            neg_q_r  <= 1'b0;
            neg_r_r  <= 1'b0;
            hi_r     <= {W{1'b0}};
            lo_r     <= {W{1'b0}};
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            busy_r <= (state_s != IDLE);
            done_r <= 1'b0;
            if (accept_s) begin
                case (bus.op)
                    OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                        mag_a_r  <= magnitude(bus.src_a, !bus.op[0]);
                        mag_b_r  <= magnitude(bus.src_b, !bus.op[0]);
                        a_r      <= bus.src_a;
                        is_div_r <= bus.op[1];
                        b_zero_r <= (bus.src_b == {W{1'b0}});
                        neg_q_r  <= !bus.op[0] && (bus.src_a[W-1] ^ bus.src_b[W-1]);
                        neg_r_r  <= !bus.op[0] && bus.src_a[W-1];
                        cnt_r    <= {CW{1'b0}};
                        // Divide iterates over the dividend, multiply over the multiplier
                        p_r      <= {{W{1'b0}}, bus.op[1] ? magnitude(bus.src_a, !bus.op[0])
                                                          : magnitude(bus.src_b, !bus.op[0])};
                    end
                    OP_MTHI: hi_r <= bus.src_a;
                    OP_MTLO: lo_r <= bus.src_a;
                    default: ;
                endcase
            end else if (state_r == RUN && !bus.cancel) begin
                p_r   <= is_div_r ? div_next_s : mul_next_s;
                cnt_r <= cnt_r + CW'(1);
            end else if (state_r == FIX && !bus.cancel) begin
                hi_r   <= res_hi_s;
                lo_r   <= res_lo_s;
                done_r <= 1'b1;
            end else begin
                cnt_r <= cnt_r;
            end
        end
    end

    assign bus.busy = busy_r;
    assign bus.done = done_r;
    assign bus.hi   = hi_r;
    assign bus.lo   = lo_r;
endmodule
